// File: rtl/auth_pkg.sv
// Shared constants and FSM state type for the rider authorization link.
// The authorization receiver decodes the same command bytes.
package auth_pkg;

  localparam logic [7:0] CMD_GO   = 8'h67;
  localparam logic [7:0] CMD_STOP = 8'h73;

  typedef enum logic {
    IDLE,
    SHIFT
  } cmd_state_t;

endpackage

// File: rtl/auth_uart_tx.sv
// 8N1 UART transmitter, LSB first; trmt loads tx_data when idle and TX falls on that edge.
// Frame lasts 10*BAUD_DIV clocks; tx_done marks the final clock of the stop bit.
module auth_uart_tx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       busy,
  output logic       tx_done
);

  localparam int BW = $clog2(BAUD_DIV);

  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shift;
  logic          baud_end;

  assign baud_end = (baud_cnt == BW'(BAUD_DIV - 1));
  assign tx_done  = busy && baud_end && (bit_cnt == 4'd9);

  // shift holds {stop, data}; the start bit is driven directly on load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      TX       <= 1'b1;
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '1;
    end else if (trmt && !busy) begin
      TX       <= 1'b0;
      busy     <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= {1'b1, tx_data};
    end else if (busy) begin
      if (baud_end) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          busy    <= 1'b0;
          bit_cnt <= '0;
          TX      <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          TX      <= shift[0];
          shift   <= {1'b1, shift[8:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + BW'(1);
      end
    end
  end

endmodule

// File: rtl/auth_cmd_tx.sv
// Turns go/stop request pulses into 'g'/'s' UART bytes, stop wins; start bit one clock after the request.
// One pending command per type absorbs requests while busy; AUTH_HEARTBEAT_EN enables periodic 'g' resends.
module auth_cmd_tx
  import auth_pkg::*;
#(
  parameter int BAUD_DIV  = 2604,
  parameter int HB_CYCLES = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go_req,
  input  logic stop_req,
  output logic TX,
  output logic busy,
  output logic tx_done,
  output logic linked
);

  if (BAUD_DIV < 4 || BAUD_DIV > 4095 || HB_CYCLES < 2) begin : g_bad_param
    $error("auth_cmd_tx: BAUD_DIV must be 4..4095 and HB_CYCLES at least 2");
  end

  cmd_state_t state, state_nxt;
  logic       pend_g, pend_s, pend_g_nxt, pend_s_nxt;
  logic       load_g, load_s, trmt, cur_go, hb_fire;
  logic [7:0] tx_data;

  auth_uart_tx #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (trmt),
    .tx_data (tx_data),
    .TX      (TX),
    .busy    (busy),
    .tx_done (tx_done)
  );

  always_comb begin
    state_nxt = state;
    trmt      = 1'b0;
    tx_data   = CMD_GO;
    load_g    = 1'b0;
    load_s    = 1'b0;
    case (state)
      IDLE: begin
        if (pend_s) begin
          trmt      = 1'b1;
          tx_data   = CMD_STOP;
          load_s    = 1'b1;
          state_nxt = SHIFT;
        end else if (pend_g) begin
          trmt      = 1'b1;
          tx_data   = CMD_GO;
          load_g    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (tx_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The flag being loaded clears first so a same-cycle request re-arms it
  always_comb begin
    pend_s_nxt = pend_s & ~load_s;
    pend_g_nxt = pend_g & ~load_g;
    if (stop_req) begin
      pend_s_nxt = 1'b1;
      pend_g_nxt = 1'b0;
    end else if (go_req || hb_fire) begin
      pend_g_nxt = 1'b1;
      pend_s_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      pend_g <= 1'b0;
      pend_s <= 1'b0;
      cur_go <= 1'b0;
      linked <= 1'b0;
    end else begin
      state  <= state_nxt;
      pend_g <= pend_g_nxt;
      pend_s <= pend_s_nxt;
      if (trmt) cur_go <= load_g;
      if (tx_done) linked <= cur_go;
    end
  end

`ifdef AUTH_HEARTBEAT_EN
  localparam int HBW = $clog2(HB_CYCLES);

  logic [HBW-1:0] hb_cnt;
  logic           hb_run;

  assign hb_run  = linked && (state == IDLE) && !pend_g && !pend_s;
  assign hb_fire = hb_run && (hb_cnt == HBW'(HB_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || !hb_run || hb_fire) begin
      hb_cnt <= '0;
    end else begin
      hb_cnt <= hb_cnt + HBW'(1);
    end
  end
`else
  assign hb_fire = 1'b0;
`endif

endmodule

// File: tb/tb_auth_cmd_tx.sv
// Bench for auth_cmd_tx: scenario table plus hand sequences, frames decoded off TX into a scoreboard.
// Build with AUTH_HEARTBEAT_EN defined to exercise the periodic resend instead of its absence.
module tb_auth_cmd_tx;
  import auth_pkg::*;

  localparam int BD = 16;
  localparam int HB = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic go_req = 1'b0;
  logic stop_req = 1'b0;
  logic TX, busy, tx_done, linked;

  int n_cmp = 0;
  int n_bad = 0;
  int frames_seen = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       g0;
    logic       s0;
    int         mid_go;
    logic       mid_s;
    int         nexp;
    logic [7:0] e0;
    logic [7:0] e1;
    logic       exp_link;
  } vec_t;

  auth_cmd_tx #(.BAUD_DIV(BD), .HB_CYCLES(HB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .go_req   (go_req),
    .stop_req (stop_req),
    .TX       (TX),
    .busy     (busy),
    .tx_done  (tx_done),
    .linked   (linked)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic g, input logic s);
    @(posedge clk); #1;
    go_req = g;
    stop_req = s;
    @(posedge clk); #1;
    go_req = 1'b0;
    stop_req = 1'b0;
  endtask

  task automatic quiet(input string name, input int cycles);
    int hits;
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) hits++;
    end
    check(name, hits, 0);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((busy !== 1'b0 || exp_q.size() != 0) && t < budget);
    check(name, (t < budget), 1);
  endtask

  // Frame decoder: samples mid-bit, abandons the frame if reset is seen
  initial begin : monitor
    logic [7:0] b;
    bit ab;
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && TX === 1'b0) begin
        ab = 1'b0;
        b = '0;
        for (int k = 0; k < 10 * BD; k++) begin
          if (k > 0) @(negedge clk);
          if (rst_n !== 1'b1) begin
            ab = 1'b1;
            break;
          end
          if (k % BD == BD / 2) begin
            if (k / BD == 0) check("start_bit", TX, 0);
            else if (k / BD <= 8) b[k / BD - 1] = TX;
            else check("stop_bit", TX, 1);
          end
          if (k == 10 * BD - 2) check("tx_done_early", tx_done, 0);
          if (k == 10 * BD - 1) check("tx_done_last_clk", tx_done, 1);
        end
        if (!ab) begin
          frames_seen++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_frame: got byte %0h, expected no frame", b);
          end else begin
            want = exp_q.pop_front();
            check("frame_byte", b, want);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin : main
    vec_t tbl[8];
    int f0;
    int t;

    tbl[0] = '{1'b1, 1'b0, 0, 1'b0, 1, CMD_GO,   8'h00,    1'b1};
    tbl[1] = '{1'b1, 1'b1, 0, 1'b0, 1, CMD_STOP, 8'h00,    1'b0};
    tbl[2] = '{1'b1, 1'b0, 0, 1'b1, 2, CMD_GO,   CMD_STOP, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 2, 1'b1, 2, CMD_GO,   CMD_STOP, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1, 1'b0, 2, CMD_STOP, CMD_GO,   1'b1};
    tbl[5] = '{1'b1, 1'b0, 2, 1'b0, 2, CMD_GO,   CMD_GO,   1'b1};
    tbl[6] = '{1'b0, 1'b1, 0, 1'b0, 1, CMD_STOP, 8'h00,    1'b0};
    tbl[7] = '{1'b0, 1'b1, 2, 1'b0, 2, CMD_STOP, CMD_GO,   1'b1};

    // Reset values and first-frame latency
    repeat (3) @(posedge clk);
    #1;
    check("rst_TX", TX, 1);
    check("rst_busy", busy, 0);
    check("rst_linked", linked, 0);
    check("rst_tx_done", tx_done, 0);
    rst_n = 1'b1;
    exp_q.push_back(CMD_GO);
    pulse(1'b1, 1'b0);
    check("no_start_on_sample_edge", TX, 1);
    check("busy_low_on_sample_edge", busy, 0);
    @(posedge clk); #1;
    check("start_on_next_edge", TX, 0);
    check("busy_on_load", busy, 1);
    t = 0;
    while (tx_done !== 1'b1 && t < 20 * BD) begin
      @(negedge clk);
      t++;
    end
    check("tx_done_clock", t, 10 * BD);
    check("linked_before_done_edge", linked, 0);
    @(posedge clk); #1;
    check("linked_after_go", linked, 1);
    check("busy_after_done", busy, 0);
    check("TX_idle_after_done", TX, 1);
    wait_drain("first_drain", 20 * BD);

    for (int i = 0; i < 8; i++) begin
      f0 = frames_seen;
      exp_q.push_back(tbl[i].e0);
      if (tbl[i].nexp == 2) exp_q.push_back(tbl[i].e1);
      pulse(tbl[i].g0, tbl[i].s0);
      if (tbl[i].mid_go > 0 || tbl[i].mid_s) begin
        repeat (20) @(negedge clk);
        for (int j = 0; j < tbl[i].mid_go; j++) pulse(1'b1, 1'b0);
        if (tbl[i].mid_s) pulse(1'b0, 1'b1);
      end
      wait_drain($sformatf("vec%0d_drain", i), 40 * BD);
      quiet($sformatf("vec%0d_quiet", i), 11 * BD);
      check($sformatf("vec%0d_frames", i), frames_seen - f0, tbl[i].nexp);
      check($sformatf("vec%0d_linked", i), linked, tbl[i].exp_link);
    end

    // Reset during bit 4 with a stop queued behind the running frame
    f0 = frames_seen;
    pulse(1'b1, 1'b0);
    repeat (2 * BD) @(negedge clk);
    pulse(1'b0, 1'b1);
    repeat (2 * BD) @(negedge clk);
    check("busy_before_reset", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_TX", TX, 1);
    check("midrst_busy", busy, 0);
    check("midrst_linked", linked, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    quiet("midrst_no_frame", 12 * BD);
    check("midrst_frames", frames_seen - f0, 0);
    check("midrst_linked_after", linked, 0);

`ifdef AUTH_HEARTBEAT_EN
    f0 = frames_seen;
    repeat (3) exp_q.push_back(CMD_GO);
    pulse(1'b1, 1'b0);
    wait_drain("hb_resend_drain", 3 * (10 * BD + HB + 10));
    check("hb_frames", frames_seen - f0, 3);
    exp_q.push_back(CMD_STOP);
    pulse(1'b0, 1'b1);
    wait_drain("hb_stop_drain", 20 * BD);
    quiet("hb_none_after_stop", 3 * HB);
    check("hb_frames_after_stop", frames_seen - f0, 4);
    check("hb_linked_after_stop", linked, 0);
`else
    f0 = frames_seen;
    exp_q.push_back(CMD_GO);
    pulse(1'b1, 1'b0);
    wait_drain("nohb_drain", 20 * BD);
    quiet("nohb_no_resend", 3 * HB);
    check("nohb_frames", frames_seen - f0, 1);
    check("nohb_linked", linked, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/auth_cmd_tx.md
Name: auth_cmd_tx

Overview:
Remote-side transmitter for the rider authorization protocol. Converts rider-control request pulses into single-byte UART commands: 'g' (8'h67) to power up and 's' (8'h73) to release. It drives the serial line consumed by the Segway authorization receiver. It holds at most one pending command per type, gives stop priority, and tracks link state.

Parameters:
BAUD_DIV, 2604, clocks per UART bit period (50 MHz / 19200 baud); legal range 4..4095.
HB_CYCLES, 25000000, idle clocks between heartbeat 'g' resends (used only with the optional feature).

Ports:
clk  input  1  system clock, all logic on the rising edge
rst_n  input  1  synchronous active-low reset
go_req  input  1  single-cycle pulse requesting a 'g' command
stop_req  input  1  single-cycle pulse requesting an 's' command
TX  output  1  UART serial out, 8N1, LSB first, idle high
busy  output  1  high while a frame is being shifted out
tx_done  output  1  single-cycle pulse on the last clock of a stop bit
linked  output  1  high after a 'g' frame completes; low after an 's' frame completes

Behaviour:
- Reset: one clock, synchronous, active-low; rst_n sampled low at a rising clk edge. Values after that edge: TX=1, busy=0, tx_done=0, linked=0, pending flags cleared, FSM=IDLE, baud/bit counters=0.
- Reset mid-frame aborts the frame; TX returns high on that same edge.
- Pending flags pend_g and pend_s, set on the edge that samples the request:
  - stop_req sets pend_s and clears pend_g.
  - go_req sets pend_g and clears pend_s, unless stop_req is high in the same cycle; stop wins and go is dropped.
  - A repeated request of the same type while one is pending merges into that pending command.
- Command FSM, states IDLE, SHIFT:
  - IDLE: pend_s selects 8'h73; otherwise pend_g selects 8'h67. The selected flag is cleared, the byte is loaded into the shifter, busy=1, and the FSM goes to SHIFT. With no pending flag it stays in IDLE.
  - SHIFT: a request arriving now only updates the pending flags. On tx_done: busy=0, FSM goes to IDLE. A pending command starts on the next cycle, so there is exactly 1 idle clock of TX high between frames.
- Latency: request sampled at edge N sets its flag; the IDLE load happens at edge N+1, and TX falls (start bit) at that same edge.
- Framing: start bit 0, then data[0]..data[7], then stop bit 1. Each bit lasts exactly BAUD_DIV clocks, so a frame is 10*BAUD_DIV clocks.
- Counters: baud counter is ceil(log2(BAUD_DIV)) bits and wraps to 0 at BAUD_DIV-1; bit counter runs 0..9. tx_done asserts during clock 10*BAUD_DIV-1 of the frame.
- linked updates on tx_done: set to 1 if the completed byte was 8'h67, cleared to 0 if it was 8'h73.

Optional Feature:
Macro AUTH_HEARTBEAT_EN.
- Defined: a heartbeat counter runs only while linked=1, FSM=IDLE and both pending flags are 0. It clears when any of those conditions is false, and on reset. On reaching HB_CYCLES-1 it sets pend_g and clears itself, so the receiver is refreshed periodically.
- Not defined: no counter is built, HB_CYCLES is unused, and 'g' is sent only on go_req.

Decomposition:
- Package auth_pkg: CMD_GO=8'h67, CMD_STOP=8'h73, and the command-FSM state enum. The authorization receiver uses the same constants.
- One sub-module, auth_uart_tx: baud counter, bit counter, 9-bit shift register and the TX/busy/tx_done outputs, with a trmt/tx_data load handshake.
- Request pending logic, command FSM, linked and heartbeat stay in the top-level module.

Test Plan:
All scenarios use BAUD_DIV=16 and HB_CYCLES=200.
- Reset value: hold rst_n=0 for 3 clocks -> TX=1, busy=0, linked=0. Pulse go_req at cycle 5 -> TX falls at edge 6. Bits 1,1,1,0,0,1,1,0 follow, each 16 clocks. tx_done pulses at clock 165, linked=1 on the next edge.
- Go then stop: go_req, then stop_req during the 'g' frame -> 's' frame starts after 1 idle clock. It decodes as 8'h73, and linked=0 after its tx_done.
- Stop priority: go_req and stop_req in the same cycle -> only one frame, 8'h73, is sent; the go request is dropped.
- Cancel and merge: during a frame, pulse go_req twice then stop_req -> exactly one queued frame follows, 8'h73.
- Reset mid-frame: assert rst_n=0 at bit 4 of a frame -> TX=1 and busy=0 on that edge. Pending flags are cleared, no frame after release, linked=0.
- Heartbeat (with AUTH_HEARTBEAT_EN): link with 'g', then stay idle -> a 'g' frame starts every 200 idle clocks. After an 's' frame, no further 'g' frames are sent. Without the macro, no resend ever occurs.
